mem_responder: RTL and testbench

//   Memory-side responder for the datapath's MAR/MDR bus. Accepts Read/Write strobes

---
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Wait-stated word memory on the MAR/MDR bus: accept -> WAIT_STATES waits -> access -> Done pulse (Done in cycle accept+WAIT_STATES+2).
// No backpressure path: the requester holds its strobe until Done, then drops it for at least one cycle to re-arm.
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              Read,
   input  logic              Write,
   input  logic [31:0]       MAR_in,
   input  logic [DATA_W-1:0] MDR_in,
   output logic [DATA_W-1:0] Mdata,
   output logic              Done,
   output logic              busy,
   output logic              req_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_DONE,
      ST_RELEASE
   } state_t;

   typedef struct packed {
      logic              op_wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdat;
   } req_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              req_err_q, req_err_d;
   logic              mem_we;

   logic [DATA_W-1:0] mem_array [2**ADDR_W];

   if (ADDR_W < 32) begin : g_unused_mar
      logic unused_mar_hi;
      assign unused_mar_hi = ^MAR_in[31:ADDR_W];
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         mdata_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         req_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         mdata_q   <= mdata_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         req_err_q <= req_err_d;
      end
   end

   // Array contents survive clr; only an un-aborted ACCESS cycle writes.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_array[req_q.addr] <= req_q.wdat;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (Read != Write) begin
               req_d.op_wr = Write;
               req_d.addr  = MAR_in[ADDR_W-1:0];
               req_d.wdat  = MDR_in;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACCESS;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS:  state_d = ST_DONE;
         ST_DONE:    state_d = ST_RELEASE;
         ST_RELEASE: begin
            if (!Read && !Write) begin
               state_d = ST_IDLE;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mdata_d = mdata_q;
      mem_we  = 1'b0;
      if (state_q == ST_ACCESS) begin
         if (req_q.op_wr) begin
            mem_we = !clr;
         end else begin
            mdata_d = mem_array[req_q.addr];
         end
      end
      req_err_d = (state_q == ST_IDLE) && Read && Write;
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   assign Mdata   = mdata_q;
   assign Done    = done_q;
   assign busy    = busy_q;
   assign req_err = req_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: default build plus a zero-wait-state build, checked against a word-array model.
module tb_mem_responder;

   logic        clk;
   logic        clr;
   logic        Read, Write, Read0, Write0;
   logic [31:0] MAR_in, MDR_in, MAR0, MDR0;
   logic [31:0] Mdata, Mdata0;
   logic        Done, busy, req_err, Done0, busy0, req_err0;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) dut (
      .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MAR_in(MAR_in), .MDR_in(MDR_in),
      .Mdata(Mdata), .Done(Done), .busy(busy), .req_err(req_err)
   );

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .clr(clr), .Read(Read0), .Write(Write0), .MAR_in(MAR0), .MDR_in(MDR0),
      .Mdata(Mdata0), .Done(Done0), .busy(busy0), .req_err(req_err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;

   always @(negedge clk) if (Done) done_cnt++;

   // Reference: one word array per build, indexed by the address modulo the depth.
   logic [31:0] ref_mem [2][512];
   bit          known   [2][512];
   logic [31:0] mdl_mdata [2];
   bit          mdl_ok    [2];

   typedef struct {
      bit          wr;
      logic [31:0] mar;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mdata_of(input bit z);
      return z ? Mdata0 : Mdata;
   endfunction

   function automatic logic done_of(input bit z);
      return z ? Done0 : Done;
   endfunction

   function automatic logic busy_of(input bit z);
      return z ? busy0 : busy;
   endfunction

   task automatic drive(input bit z, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      if (z) begin
         Read0 = r; Write0 = w; MAR0 = a; MDR0 = d;
      end else begin
         Read = r; Write = w; MAR_in = a; MDR_in = d;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_req(input bit z, input bit wr, input logic [31:0] mar, input logic [31:0] dat, input string nm);
      int lat;
      bit seen;
      int idx;
      idx = int'(mar % 32'd512);
      drive(z, !wr, wr, mar, dat);
      @(posedge clk);
      lat  = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_of(z)) begin
            seen = 1;
            break;
         end
         lat++;
         @(posedge clk);
      end
      // Done is high during the cycle ending at edge accept + WAIT_STATES + 2.
      chk({nm, "_done_cycle"}, seen ? lat + 1 : 99, z ? 2 : 4);
      chk({nm, "_busy_at_done"}, {31'b0, busy_of(z)}, 1);
      if (wr) begin
         if (mdl_ok[z]) chk({nm, "_wr_keeps_mdata"}, mdata_of(z), mdl_mdata[z]);
         ref_mem[z][idx] = dat;
         known[z][idx]   = 1;
      end else if (known[z][idx]) begin
         chk({nm, "_rd_data"}, mdata_of(z), ref_mem[z][idx]);
         mdl_mdata[z] = ref_mem[z][idx];
         mdl_ok[z]    = 1;
      end else begin
         mdl_ok[z] = 0;
      end
      drive(z, 0, 0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({nm, "_idle_busy"}, {31'b0, busy_of(z)}, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dc;
      bit wr;
      logic [31:0] a, d;

      vecs[0] = '{1, 32'h0000_0055, 32'h0000_0067, 32'h0};
      vecs[1] = '{0, 32'h0000_0055, 32'h0,         32'h0000_0067};
      vecs[2] = '{1, 32'h0000_0203, 32'h1234_5678, 32'h0};
      vecs[3] = '{0, 32'h0000_0003, 32'h0,         32'h1234_5678};
      vecs[4] = '{1, 32'h0000_01FF, 32'hCAFE_F00D, 32'h0};
      vecs[5] = '{0, 32'hFFFF_FFFF, 32'h0,         32'hCAFE_F00D};
      vecs[6] = '{1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0};
      vecs[7] = '{0, 32'h0000_0200, 32'h0,         32'h0BAD_F00D};

      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 512; i++) known[z][i] = 0;
         mdl_mdata[z] = 32'h0;
         mdl_ok[z]    = 1;
      end

      clr = 1'b1;
      drive(0, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", {31'b0, Done}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_req_err", {31'b0, req_err}, 0);
      chk("rst_mdata", Mdata, 32'h0);
      chk("rst_mdata_ws0", Mdata0, 32'h0);
      clr = 1'b0;
      @(negedge clk);

      // Table: write/read pairs including address aliasing and the top word.
      for (int i = 0; i < 8; i++) begin
         do_req(0, vecs[i].wr, vecs[i].mar, vecs[i].dat, $sformatf("vec%0d", i));
         if (!vecs[i].wr) chk($sformatf("vec%0d_table", i), Mdata, vecs[i].exp);
      end

      // Read held for 10 cycles: one access, then a clean re-arm.
      dc = done_cnt;
      drive(0, 1, 0, 32'h0000_0055, 32'h0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("hold_done_count", done_cnt - dc, 1);
      chk("hold_busy", {31'b0, busy}, 1);
      chk("hold_mdata", Mdata, 32'h0000_0067);
      drive(0, 0, 0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("hold_released", {31'b0, busy}, 0);
      dc = done_cnt;
      do_req(0, 0, 32'h0000_0055, 32'h0, "rearm");
      chk("rearm_done_count", done_cnt - dc, 1);

      // Both strobes high in IDLE.
      drive(0, 1, 1, 32'h0000_0055, 32'hFFFF_FFFF);
      @(posedge clk);
      @(negedge clk);
      chk("both_req_err", {31'b0, req_err}, 1);
      chk("both_busy", {31'b0, busy}, 0);
      drive(0, 0, 0, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("both_req_err_pulse", {31'b0, req_err}, 0);
      chk("both_busy_after", {31'b0, busy}, 0);
      chk("both_mdata", Mdata, mdl_mdata[0]);
      do_req(0, 0, 32'h0000_0055, 32'h0, "both_nochange");

      // clr mid-WAIT aborts a write.
      do_req(0, 1, 32'h0000_0010, 32'h1111_2222, "pre_abort");
      dc = done_cnt;
      drive(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
      @(posedge clk);
      @(negedge clk);
      chk("abort_in_wait", {31'b0, busy}, 1);
      clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_mdata", Mdata, 32'h0);
      clr = 1'b0;
      drive(0, 0, 0, 32'h0, 32'h0);
      for (int z = 0; z < 2; z++) begin
         mdl_mdata[z] = 32'h0;
         mdl_ok[z]    = 1;
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      do_req(0, 0, 32'h0000_0010, 32'h0, "abort_prior");

      // Randomized traffic on a small aliased address window.
      for (int i = 0; i < 16; i++) begin
         a = ($urandom & 32'hFFFF_FE00) | 32'(i);
         do_req(0, 1, a, $urandom, "rnd_init");
      end
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 15));
         d  = $urandom;
         do_req(0, wr, a, d, "rnd");
      end

      // Zero-wait-state build.
      do_req(1, 1, 32'h0000_0000, 32'hA5A5_A5A5, "ws0_pre");
      do_req(1, 0, 32'h0000_0000, 32'h0, "ws0_rd");
      chk("ws0_mdata", Mdata0, 32'hA5A5_A5A5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
